// File: rtl/seq_pkg.sv
// Shared definitions for the device bring-up / register-read sequencer.
// Contents:
//   - state_e  : 4-bit FSM state codes, also shown on the 7-seg display
//   - sel_w()  : width of a device-index field for a given device count
package seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_STARTUP    = 4'd1,
    S_INIT_START = 4'd2,
    S_INIT_WAIT  = 4'd3,
    S_RD_START   = 4'd4,
    S_RD_WAIT    = 4'd5,
    S_INIT_NEXT  = 4'd6
  } state_e;

  // A single device still needs a 1-bit select field.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dev_init_sequencer_if.sv
// Handshake bundle between the sequencer and the per-device init / reg-read
// blocks, plus the operator read-request inputs.
//   init_start / rd_start : one-cycle start pulses, one bit per device
//   init_done  / rd_done  : level done flags, one bit per device
//   rd_req_n              : active-low operator read request (button level)
//   rd_sel                : device index for the read request
// master = sequencer side, slave = device / operator side.
interface dev_init_sequencer_if #(
  parameter int N_DEV = 2,
  parameter int SEL_W = seq_pkg::sel_w(N_DEV)
) ();
  logic [N_DEV-1:0] init_start;
  logic [N_DEV-1:0] init_done;
  logic [N_DEV-1:0] rd_start;
  logic [N_DEV-1:0] rd_done;
  logic             rd_req_n;
  logic [SEL_W-1:0] rd_sel;

  modport master (
    output init_start, rd_start,
    input  init_done, rd_done, rd_req_n, rd_sel
  );

  modport slave (
    input  init_start, rd_start,
    output init_done, rd_done, rd_req_n, rd_sel
  );
endinterface

// File: rtl/dev_init_sequencer_us_timer.sv
// Microsecond timebase for the sequencer.
//   clk, reset : system clock, async active-low reset
//   clr        : synchronous clear of prescaler and counter
//   us_cnt     : microseconds elapsed since the last clear, saturating
module us_timer #(
  parameter int CLK_PER_US = 50,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [CNT_W-1:0] us_cnt
);
  localparam int PW = $clog2(CLK_PER_US);

  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             us_tick;

  assign us_tick = (presc_q == PW'(CLK_PER_US - 1));
  assign us_cnt  = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= us_tick ? '0 : presc_q + 1'b1;
      // Hold at all-ones so a long idle never wraps into a short delay.
      if (us_tick && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/dev_init_sequencer.sv
// Bring-up and register-read sequencer for N_DEV I2C-configured peripherals.
// After reset it waits STARTUP_US, then initialises each device in index
// order (start pulse, settle, done/timeout with retry), then services
// operator register-read requests to initialised devices.
// Ports:
//   clk, reset : system clock, async active-low reset
//   bus        : start/done handshakes and read request (master modport)
//   cur_dev    : device being initialised or read
//   state_out  : FSM state code for the 7-seg display
//   init_ok    : sticky per-device init success
//   init_err   : sticky per-device retries exhausted
//   all_ready  : every device initialised
//   busy       : FSM not idle
//   rd_rej     : one-cycle pulse, read rejected or read timed out
module dev_init_sequencer
  import seq_pkg::*;
#(
  parameter int N_DEV      = 2,
  parameter int CLK_PER_US = 50,
  parameter int CNT_W      = 32,
  parameter int STARTUP_US = 500000,
  parameter int SETTLE_US  = 500000,
  parameter int TIMEOUT_US = 1000000,
  parameter int MAX_RETRY  = 2,
  parameter int READ_US    = 100,
  localparam int SEL_W     = sel_w(N_DEV)
) (
  input  logic                 clk,
  input  logic                 reset,
  dev_init_sequencer_if.master bus,
  output logic [SEL_W-1:0]     cur_dev,
  output logic [3:0]           state_out,
  output logic [N_DEV-1:0]     init_ok,
  output logic [N_DEV-1:0]     init_err,
  output logic                 all_ready,
  output logic                 busy,
  output logic                 rd_rej
);
  localparam int NX    = 1 << SEL_W;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] STARTUP_C = CNT_W'(STARTUP_US);
  localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE_US);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] READ_C    = CNT_W'(READ_US);
  localparam logic [SEL_W-1:0] LAST_DEV  = SEL_W'(N_DEV - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

  state_e           state_q, state_prev_q;
  logic [SEL_W-1:0] cur_dev_q;
  logic [RTY_W-1:0] retry_q;
  logic [N_DEV-1:0] init_start_q, rd_start_q, init_ok_q, init_err_q;
  logic             rd_rej_q;

  logic [CNT_W-1:0] us_cnt;
  logic             tmr_clr;
  logic [N_DEV-1:0] cur_oh;
  logic [NX-1:0]    ok_x, done_x, rd_done_x;

  // Timer restarts on every state change. The clear is taken from the
  // previous-state register so the FSM stays a single registered block; the
  // one-cycle lag only affects states that never look at us_cnt on entry.
  assign tmr_clr = (state_q != state_prev_q);

  us_timer #(
    .CLK_PER_US(CLK_PER_US),
    .CNT_W     (CNT_W)
  ) u_tmr (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .us_cnt(us_cnt)
  );

  // Vectors padded to a power of two so any SEL_W-bit index is in range;
  // padding bits of ok_x read as 0, which rejects rd_sel >= N_DEV for free.
  assign ok_x      = NX'(init_ok_q);
  assign done_x    = NX'(bus.init_done);
  assign rd_done_x = NX'(bus.rd_done);
  assign cur_oh    = N_DEV'(NX'(1) << cur_dev_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_STARTUP;
      state_prev_q <= S_STARTUP;
      cur_dev_q    <= '0;
      retry_q      <= '0;
      init_start_q <= '0;
      rd_start_q   <= '0;
      init_ok_q    <= '0;
      init_err_q   <= '0;
      rd_rej_q     <= 1'b0;
    end else begin
      state_prev_q <= state_q;
      init_start_q <= '0;
      rd_start_q   <= '0;
      rd_rej_q     <= 1'b0;
      unique case (state_q)
        S_STARTUP: begin
          if (us_cnt >= STARTUP_C) state_q <= S_INIT_START;
        end
        S_INIT_START: begin
          init_start_q <= cur_oh;
          state_q      <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          // Done is checked first so it wins over a coincident timeout.
          if ((us_cnt >= SETTLE_C) && done_x[cur_dev_q]) begin
            init_ok_q <= init_ok_q | cur_oh;
            state_q   <= S_INIT_NEXT;
          end else if (us_cnt >= TIMEOUT_C) begin
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + 1'b1;
              state_q <= S_INIT_START;
            end else begin
              init_err_q <= init_err_q | cur_oh;
              state_q    <= S_INIT_NEXT;
            end
          end
        end
        S_INIT_NEXT: begin
          if (cur_dev_q == LAST_DEV) begin
            state_q <= S_IDLE;
          end else begin
            cur_dev_q <= cur_dev_q + 1'b1;
            retry_q   <= '0;
            state_q   <= S_INIT_START;
          end
        end
        S_IDLE: begin
          if (!bus.rd_req_n) begin
            if (ok_x[bus.rd_sel]) begin
              cur_dev_q <= bus.rd_sel;
              state_q   <= S_RD_START;
            end else begin
              rd_rej_q <= 1'b1;
            end
          end
        end
        S_RD_START: begin
          rd_start_q <= cur_oh;
          state_q    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if ((us_cnt >= READ_C) && rd_done_x[cur_dev_q]) begin
            state_q <= S_IDLE;
          end else if (us_cnt >= TIMEOUT_C) begin
            rd_rej_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.init_start = init_start_q;
  assign bus.rd_start   = rd_start_q;
  assign cur_dev        = cur_dev_q;
  assign state_out      = state_q;
  assign init_ok        = init_ok_q;
  assign init_err       = init_err_q;
  assign rd_rej         = rd_rej_q;
  assign all_ready      = &init_ok_q;
  assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_dev_init_sequencer.sv
// Randomised bench for dev_init_sequencer. Device init / reg-read blocks are
// modelled as "done rises d cycles after my start pulse" (or never). The
// expected pulse order, gaps, sticky flags and read outcomes are derived from
// the microsecond rules: each wait of n us lasts about n*CLK_PER_US cycles,
// plus a few cycles of state overhead.
module tb_dev_init_sequencer;
  import seq_pkg::*;

  localparam int N_DEV      = 3;
  localparam int CLK_PER_US = 4;
  localparam int STARTUP_US = 10;
  localparam int SETTLE_US  = 5;
  localparam int TIMEOUT_US = 20;
  localparam int MAX_RETRY  = 1;
  localparam int READ_US    = 3;
  localparam int SEL_W      = 2;
  localparam int NEVER      = 1000000;
  localparam int SLACK      = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [SEL_W-1:0] cur_dev;
  logic [3:0]       state_out;
  logic [N_DEV-1:0] init_ok, init_err;
  logic             all_ready, busy, rd_rej;

  dev_init_sequencer_if #(.N_DEV(N_DEV), .SEL_W(SEL_W)) bus ();

  dev_init_sequencer #(
    .N_DEV(N_DEV), .CLK_PER_US(CLK_PER_US), .CNT_W(32),
    .STARTUP_US(STARTUP_US), .SETTLE_US(SETTLE_US), .TIMEOUT_US(TIMEOUT_US),
    .MAX_RETRY(MAX_RETRY), .READ_US(READ_US)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cur_dev(cur_dev), .state_out(state_out), .init_ok(init_ok),
    .init_err(init_err), .all_ready(all_ready), .busy(busy), .rd_rej(rd_rej)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- device models and pulse monitor ----------------
  typedef struct { int t; int idx; } ev_t;
  ev_t pq[$];
  int  cyc  = 0;
  int  viol = 0;
  int  dly [N_DEV][MAX_RETRY+1];   // per device, per attempt done delay
  int  rdly = NEVER;
  int  att   [N_DEV];
  int  since [N_DEV];
  int  cur_d [N_DEV];
  int  rsince = NEVER;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.init_start != '0) begin
      if ($countones(bus.init_start) != 1) viol++;
      for (int i = 0; i < N_DEV; i++)
        if (bus.init_start[i]) pq.push_back('{t: cyc, idx: i});
    end
    if ($countones(bus.rd_start) > 1) viol++;
    if ((bus.init_start != '0) && (bus.rd_start != '0)) viol++;
    if (((state_out == 4'd0) || (state_out == 4'd1)) &&
        ((bus.init_start | bus.rd_start) != '0)) viol++;
    for (int i = 0; i < N_DEV; i++) begin
      if (!reset) begin
        att[i] = 0; since[i] = NEVER; cur_d[i] = NEVER;
      end else if (bus.init_start[i]) begin
        since[i] = 0;
        cur_d[i] = dly[i][(att[i] > MAX_RETRY) ? MAX_RETRY : att[i]];
        att[i]++;
      end else if (since[i] < NEVER) begin
        since[i]++;
      end
      bus.init_done[i] = (since[i] >= cur_d[i]);
    end
    if (bus.rd_start != '0) rsince = 0;
    else if (rsince < NEVER) rsince++;
    bus.rd_done = (rsince >= rdly) ? '1 : '0;
  end

  // ---------------- checks ----------------
  logic [N_DEV-1:0] eok_g;

  task automatic chk_rst(input string tag);
    chk({tag, "_state"},      int'(state_out), 1);
    chk({tag, "_busy"},       int'(busy), 1);
    chk({tag, "_cur_dev"},    int'(cur_dev), 0);
    chk({tag, "_init_start"}, int'(bus.init_start), 0);
    chk({tag, "_rd_start"},   int'(bus.rd_start), 0);
    chk({tag, "_init_ok"},    int'(init_ok), 0);
    chk({tag, "_init_err"},   int'(init_err), 0);
    chk({tag, "_all_ready"},  int'(all_ready), 0);
    chk({tag, "_rd_rej"},     int'(rd_rej), 0);
  endtask

  // mode 0: random delays, 1: every device answers at once,
  // 2: device 1 never answers, others at once
  task automatic run_init(input int mode);
    int base, vbase, rel, idle_t, g, t0;
    bit got_idle;
    logic [N_DEV-1:0] eok, eerr;
    int eidx[$], lo[$];
    @(negedge clk);
    reset = 1'b0;
    bus.rd_req_n = 1'b1;
    for (int i = 0; i < N_DEV; i++)
      for (int a = 0; a <= MAX_RETRY; a++)
        dly[i][a] = (mode == 1) ? 0 :
                    (mode == 2) ? ((i == 1) ? NEVER : 0) :
                    (($urandom_range(0, 2) == 0) ? NEVER : int'($urandom_range(0, 70)));
    repeat (2) @(negedge clk);
    base  = pq.size();
    vbase = viol;
    reset = 1'b1;
    rel   = cyc;
    // expected attempt list from the retry rules
    eok = '0; eerr = '0;
    for (int i = 0; i < N_DEV; i++) begin
      for (int a = 0; a <= MAX_RETRY; a++) begin
        eidx.push_back(i);
        if (dly[i][a] != NEVER) begin
          lo.push_back(imax(CLK_PER_US * SETTLE_US, dly[i][a]));
          eok[i] = 1'b1;
          break;
        end
        lo.push_back(CLK_PER_US * TIMEOUT_US);
        if (a == MAX_RETRY) eerr[i] = 1'b1;
      end
    end
    got_idle = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (state_out == 4'd0) begin got_idle = 1'b1; break; end
    end
    idle_t = cyc;
    chk("init_reaches_idle", int'(got_idle), 1);
    chk("init_pulse_count", pq.size() - base, eidx.size());
    if (pq.size() - base == eidx.size()) begin
      g = pq[base].t - rel;
      chk($sformatf("startup_delay=%0d_in[%0d,%0d]", g, CLK_PER_US * STARTUP_US,
          CLK_PER_US * STARTUP_US + SLACK),
          int'(g >= CLK_PER_US * STARTUP_US && g <= CLK_PER_US * STARTUP_US + SLACK), 1);
      for (int j = 0; j < eidx.size(); j++) begin
        chk($sformatf("pulse%0d_dev", j), pq[base+j].idx, eidx[j]);
        t0 = (j + 1 < eidx.size()) ? pq[base+j+1].t : idle_t;
        g  = t0 - pq[base+j].t;
        chk($sformatf("pulse%0d_gap=%0d_in[%0d,%0d]", j, g, lo[j], lo[j] + SLACK),
            int'(g >= lo[j] && g <= lo[j] + SLACK), 1);
      end
    end
    chk("init_ok",   int'(init_ok), int'(eok));
    chk("init_err",  int'(init_err), int'(eerr));
    chk("all_ready", int'(all_ready), int'(&eok));
    chk("idle_busy", int'(busy), 0);
    chk("idle_cur_dev", int'(cur_dev), N_DEV - 1);
    chk("start_onehot_viol", viol - vbase, 0);
    eok_g = eok;
  endtask

  task automatic do_read(input int sel, input int d);
    bit acc;
    int rs_n, rs_val, rej_n, busy_n, k0, idle_t, lo, dur, vbase;
    acc = (sel < N_DEV) && eok_g[sel];
    rs_n = 0; rs_val = 0; rej_n = 0; busy_n = 0; idle_t = -1;
    vbase = viol;
    rdly = d;
    @(negedge clk);
    bus.rd_sel   = SEL_W'(sel);
    bus.rd_req_n = 1'b0;
    @(negedge clk);
    bus.rd_req_n = 1'b1;
    k0 = cyc;
    if (acc) begin
      chk($sformatf("rd%0d_state_rd_start", sel), int'(state_out), 4);
      chk($sformatf("rd%0d_cur_dev", sel), int'(cur_dev), sel);
    end
    for (int n = 0; n < 200; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.rd_start != '0) begin rs_n++; rs_val = int'(bus.rd_start); end
      if (rd_rej) rej_n++;
      if (state_out != 4'd0) busy_n++;
      else if (idle_t < 0) idle_t = cyc;
      if (idle_t >= 0 && cyc - idle_t >= 3) break;
    end
    if (!acc) begin
      chk($sformatf("rej%0d_rd_start_cycles", sel), rs_n, 0);
      chk($sformatf("rej%0d_busy_cycles", sel), busy_n, 0);
      chk($sformatf("rej%0d_rd_rej_cycles", sel), rej_n, 1);
    end else begin
      lo  = (d == NEVER) ? CLK_PER_US * TIMEOUT_US : imax(CLK_PER_US * READ_US, d);
      dur = idle_t - k0;
      chk($sformatf("rd%0d_returns_idle", sel), int'(idle_t >= 0), 1);
      chk($sformatf("rd%0d_rd_start_cycles", sel), rs_n, 1);
      chk($sformatf("rd%0d_rd_start_val", sel), rs_val, 1 << sel);
      chk($sformatf("rd%0d_rd_rej_cycles", sel), rej_n, (d == NEVER) ? 1 : 0);
      chk($sformatf("rd%0d_dur=%0d_in[%0d,%0d]", sel, dur, lo, lo + SLACK),
          int'(dur >= lo && dur <= lo + SLACK), 1);
      chk($sformatf("rd%0d_init_ok_kept", sel), int'(init_ok), int'(eok_g));
    end
    chk($sformatf("rd%0d_onehot_viol", sel), viol - vbase, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    bit got;
    bus.rd_req_n = 1'b1;
    bus.rd_sel   = '0;
    eok_g        = '0;
    for (int i = 0; i < N_DEV; i++)
      for (int a = 0; a <= MAX_RETRY; a++) dly[i][a] = 0;
    repeat (3) @(negedge clk);
    chk_rst("por");

    // reset pulled while device 1 is in its init wait
    base  = pq.size();
    reset = 1'b1;
    got   = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (pq.size() - base >= 2) begin got = 1'b1; break; end
    end
    chk("mid_reach_dev1", int'(got), 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_rst("mid");

    run_init(1);
    do_read(2, 0);
    do_read(3, 0);

    run_init(2);
    do_read(2, 0);
    do_read(1, 0);
    do_read(3, 0);
    do_read(0, NEVER);

    for (int s = 0; s < 6; s++) begin
      run_init(0);
      for (int r = 0; r < 4; r++)
        do_read(int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 40)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
